// File: rtl/hub75_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hub75_capture : HUB75 panel-side receiver, rebuilds each displayed row as a
//                 valid/ready pixel stream tagged with row address and OE weight
// Revision      : 1.0
// ---------------------------------------------------------------------------
module hub75_capture #(
  parameter int COLUMNS   = 64,
  parameter int COL_WIDTH = 6,
  parameter int OE_WIDTH  = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 hub_clk,
  input  logic                 hub_lat,
  input  logic                 hub_oe,
  input  logic [3:0]           hub_addr,
  input  logic [5:0]           hub_rgb,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic [COL_WIDTH-1:0] pixel_column,
  output logic [3:0]           pixel_row,
  output logic [5:0]           pixel_rgb,
  output logic [OE_WIDTH-1:0]  pixel_weight,
  output logic                 pixel_last,
  output logic                 err_short,
  output logic                 err_overrun,
  input  logic                 status_clear
);

  localparam int                  c_bits      = 6 * COLUMNS;
  localparam int                  c_cnt_w     = $clog2(COLUMNS + 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_full  = c_cnt_w'(COLUMNS);
  localparam logic [COL_WIDTH-1:0] c_col_last = COL_WIDTH'(COLUMNS - 1);
  localparam logic [OE_WIDTH-1:0] c_wt_max    = '1;

  typedef enum logic [1:0] {IDLE, ARMED, ON, STREAM} state_t;

  // {clk, lat, oe, addr[3:0], rgb[5:0]} travel together so all lines see equal delay
  logic [12:0]          r_sync1, r_sync2, r_stage;
  logic [2:0]           r_ctrl_prev;
  logic [c_bits-1:0]    r_shift, r_row_buf, w_shift_next;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
  state_t               r_state;
  logic [COL_WIDTH-1:0] r_col;
  logic                 w_clk_rise, w_lat_rise, w_oe_rise, w_oe_fall, w_oe_level;
  logic [3:0]           w_addr;
  logic [5:0]           w_rgb;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_stage     <= '0;
      r_ctrl_prev <= '0;
    end else begin
      r_sync1     <= {hub_clk, hub_lat, hub_oe, hub_addr, hub_rgb};
      r_sync2     <= r_sync1;
      r_stage     <= r_sync2;
      r_ctrl_prev <= r_stage[12:10];
    end
  end

  assign w_clk_rise = r_stage[12] & ~r_ctrl_prev[2];
  assign w_lat_rise = r_stage[11] & ~r_ctrl_prev[1];
  assign w_oe_rise  = r_stage[10] & ~r_ctrl_prev[0];
  assign w_oe_fall  = ~r_stage[10] & r_ctrl_prev[0];
  assign w_oe_level = r_stage[10];
  assign w_addr     = r_stage[9:6];
  assign w_rgb      = r_stage[5:0];

  // A latch in the same cycle as a clock edge copies the freshly shifted data
  assign w_shift_next = w_clk_rise ? {r_shift[c_bits-7:0], w_rgb} : r_shift;
  assign w_cnt_next   = (w_clk_rise && r_cnt != c_cnt_full) ? r_cnt + c_cnt_w'(1) : r_cnt;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_row_buf    <= '0;
      r_state      <= IDLE;
      r_col        <= '0;
      pixel_valid  <= 1'b0;
      pixel_row    <= '0;
      pixel_weight <= '0;
      err_short    <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_cnt   <= w_lat_rise ? '0 : w_cnt_next;

      if (w_lat_rise && w_cnt_next != c_cnt_full) err_short <= 1'b1;
      else if (status_clear)                      err_short <= 1'b0;

      if (w_lat_rise && r_state != IDLE) err_overrun <= 1'b1;
      else if (status_clear)             err_overrun <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_lat_rise) begin
            r_row_buf <= w_shift_next;
            r_state   <= ARMED;
          end
        end
        ARMED: begin
          if (w_lat_rise) r_row_buf <= w_shift_next;
          if (w_oe_rise) begin
            pixel_row    <= w_addr;
            pixel_weight <= OE_WIDTH'(1);
            r_state      <= ON;
          end
        end
        ON: begin
          if (w_oe_fall) begin
            r_col       <= '0;
            pixel_valid <= 1'b1;
            r_state     <= STREAM;
          end else if (w_oe_level && pixel_weight != c_wt_max) begin
            pixel_weight <= pixel_weight + OE_WIDTH'(1);
          end
        end
        STREAM: begin
          if (pixel_valid && pixel_ready) begin
            if (r_col == c_col_last) begin
              pixel_valid <= 1'b0;
              r_col       <= '0;
              r_state     <= IDLE;
            end else begin
              r_col <= r_col + COL_WIDTH'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Buffer is frozen outside IDLE/ARMED, so a direct read stays stable under backpressure
  assign pixel_column = r_col;
  assign pixel_rgb    = r_row_buf[r_col*6 +: 6];
  assign pixel_last   = (r_col == c_col_last);

endmodule
`default_nettype wire
